// File: rtl/uart_recv_cfg.sv
// uart_recv_cfg: configurable UART receiver with majority-vote sampling,
// parity/framing/break detection and false-start rejection.
module uart_recv_cfg #(
    parameter int CLK_FREQ  = 12000000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       uart_done,
    output logic [7:0] uart_data,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int CW      = $clog2(BPS_CNT);

    localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] V0      = CW'(HALF - 1);
    localparam logic [CW-1:0] V1      = CW'(HALF);
    localparam logic [CW-1:0] V2      = CW'(HALF + 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PAR     = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_BRKWAIT = 3'd5;

    logic          d0_q, d0_d, d1_q, d1_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s0_q, s0_d, s1_q, s1_d;
    logic [2:0]    idx_q, idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          pbit_q, pbit_d;
    logic          done_q, done_d;
    logic [7:0]    data_q, data_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          brk_q, brk_d;
    logic          busy_q, busy_d;

    logic start_flag, vote, at_end, at_v2;
    logic exp_par, par_bad, is_brk;

    // Next-state logic: synchroniser, bit timing, vote and frame FSM
    always_comb begin
        d0_d       = uart_rxd;
        d1_d       = d0_q;
        state_d    = state_q;
        cnt_d      = '0;
        s0_d       = s0_q;
        s1_d       = s1_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        pbit_d     = pbit_q;
        done_d     = 1'b0;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;

        start_flag = d1_q & ~d0_q;
        at_end     = (cnt_q == CNT_MAX);
        at_v2      = (cnt_q == V2);
        vote       = (s0_q & s1_q) | (s0_q & d1_q) | (s1_q & d1_q);
        exp_par    = (PARITY == 1) ? ~^shift_q : ^shift_q;
        par_bad    = (PARITY != 0) && (pbit_q != exp_par);
        is_brk     = ~vote && (shift_q == 8'h00) && ~pbit_q;

        if (state_q != S_IDLE && state_q != S_BRKWAIT) begin
            cnt_d = at_end ? '0 : cnt_q + CNT_ONE;
        end
        if (cnt_q == V0) s0_d = d1_q;
        if (cnt_q == V1) s1_d = d1_q;

        case (state_q)
            S_IDLE: begin
                if (start_flag) begin
                    state_d    = S_START;
                    shift_d    = '0;
                    idx_d      = '0;
                    stop_idx_d = 1'b0;
                    pbit_d     = 1'b0;
                end
            end
            S_START: begin
                if (at_v2 && vote) state_d = S_IDLE;
                else if (at_end)   state_d = S_DATA;
            end
            S_DATA: begin
                if (at_v2) shift_d[idx_q] = vote;
                if (at_end) begin
                    if (idx_q == LAST_BIT)
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    else
                        idx_d = idx_q + 3'd1;
                end
            end
            S_PAR: begin
                if (at_v2)  pbit_d  = vote;
                if (at_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_v2) begin
                    if (!vote || stop_idx_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        data_d  = shift_q;
                        perr_d  = par_bad;
                        ferr_d  = ~vote;
                        brk_d   = is_brk;
                        state_d = is_brk ? S_BRKWAIT : S_IDLE;
                    end
                end else if (at_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            S_BRKWAIT: begin
                if (d1_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            d0_q       <= 1'b0;
            d1_q       <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            pbit_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            pbit_q     <= pbit_d;
            done_q     <= done_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            busy_q     <= busy_d;
        end
    end

    assign uart_done  = done_q;
    assign uart_data  = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_det  = brk_q;
    assign rx_busy    = busy_q;

endmodule
